// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-channel event counters plus a run-cycle counter,
// gated by a small run/halt/timeout FSM, with a registered one-cycle read port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for en; nothing counted
// RUN     | counting cycles and events
// HALTED  | halt seen while running; frozen until clr/rst
// TIMEOUT | cycle counter reached CYC_LIMIT; frozen until clr/rst
module perf_counter_bank #(
  parameter int              NUM_EVT   = 8,
  parameter int              CNT_W     = 32,
  parameter int              SAT_MODE  = 0,
  parameter longint unsigned CYC_LIMIT = 100000,
  parameter int              SEL_W     = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clr,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT-1:0] ovf,
  output logic               done,
  output logic               timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [63:0]      LIMIT      = 64'(CYC_LIMIT);
  // A limit the cycle counter can never hold switches the timeout off entirely.
  localparam bit               TIMEOUT_EN = ((LIMIT >> CNT_W) == 64'd0);
  localparam logic [CNT_W-1:0] LIMIT_W    = LIMIT[CNT_W-1:0];
  localparam bit               SAT        = (SAT_MODE != 0);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_q [NUM_EVT];
  logic [CNT_W-1:0]   cnt_d [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_q, ovf_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]   sel_val;
  logic               count_en;
  logic               limit_hit;

  // Read mux sees registered values only, so a read never includes its own cycle's increment.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_sel == SEL_W'(i)) sel_val = cnt_q[i];
    end
    if (rd_sel == SEL_W'(NUM_EVT)) sel_val = cyc_q;
  end

  always_comb begin
    count_en = (state_q == ST_RUN);

    cyc_d = cyc_q;
    if (count_en) begin
      if (&cyc_q) cyc_d = SAT ? cyc_q : '0;
      else        cyc_d = cyc_q + CNT_W'(1);
    end

    ovf_d = ovf_q;
    for (int i = 0; i < NUM_EVT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (count_en && evt[i]) begin
        if (&cnt_q[i]) begin
          cnt_d[i] = SAT ? cnt_q[i] : '0;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    limit_hit = TIMEOUT_EN && count_en && (cyc_d == LIMIT_W);

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        // halt outranks the timeout, which outranks falling back to IDLE
        if (halt)           state_d = ST_HALTED;
        else if (limit_hit) state_d = ST_TIMEOUT;
        else if (!en)       state_d = ST_IDLE;
      end
      ST_HALTED:  state_d = ST_HALTED;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_IDLE;
    endcase

    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? sel_val : rd_data_q;

    if (clr) begin
      state_d    = ST_IDLE;
      cyc_d      = '0;
      ovf_d      = '0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      for (int i = 0; i < NUM_EVT; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_EVT; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < NUM_EVT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ovf      = ovf_q;
  assign done     = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
  assign timeout  = (state_q == ST_TIMEOUT);

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_EVT, default 8, number of event channels (1..32).
REQ-002 Parameter CNT_W, default 32, width of every event counter and the cycle counter (8..48).
REQ-003 Parameter SAT_MODE, default 0, counter overflow mode: 0 = wrap, 1 = saturate.
REQ-004 Parameter CYC_LIMIT, default 100000, cycle count that triggers timeout.
REQ-005 Parameter SEL_W, default $clog2(NUM_EVT+1), read-select width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  counting enable (CPU out of reset).
REQ-009 evt  input  NUM_EVT  per-cycle event strobes (e.g. instruction retired, I/D cache request, I/D cache hit).
REQ-010 halt  input  1  processor halt indication.
REQ-011 clr  input  1  synchronous clear of all counters, flags and state.
REQ-012 rd_req  input  1  read request strobe.
REQ-013 rd_sel  input  SEL_W  read select: 0..NUM_EVT-1 = event counter, NUM_EVT = cycle counter.
REQ-014 rd_valid  output  1  read data valid.
REQ-015 rd_data  output  CNT_W  read data.
REQ-016 ovf  output  NUM_EVT  sticky per-channel overflow flags.
REQ-017 done  output  1  high in HALTED or TIMEOUT.
REQ-018 timeout  output  1  high in TIMEOUT only.

Function
REQ-019 FSM states: IDLE, RUN, HALTED, TIMEOUT.
REQ-020 IDLE -> RUN on a cycle with en=1; nothing is counted in the transition cycle.
REQ-021 RUN: cycle counter +1 every cycle; cnt[i] +1 on every cycle with evt[i]=1; all channels update independently in the same cycle.
REQ-022 RUN -> IDLE when en=0; counter values retained.
REQ-023 RUN -> HALTED on halt=1; the halt cycle's events and cycle are counted.
REQ-024 RUN -> TIMEOUT on the cycle where the cycle counter's next value equals CYC_LIMIT; that cycle is counted.
REQ-025 halt and timeout condition in the same cycle: HALTED wins, timeout stays 0.
REQ-026 HALTED and TIMEOUT are sticky: no counting, en and halt ignored, exit only via clr or rst.
REQ-027 clr=1, any state: next state IDLE; all counters, ovf and rd_valid cleared; clr has priority over halt, timeout and counting in the same cycle.
REQ-028 Wrap mode (SAT_MODE=0): counter at all-ones plus an event -> 0; ovf[i] set.
REQ-029 Saturate mode (SAT_MODE=1): counter at all-ones holds; ovf[i] set on the first event at all-ones.
REQ-030 Cycle counter follows the same SAT_MODE rule, with no ovf bit; CYC_LIMIT >= 2^CNT_W disables timeout.
REQ-031 Read: rd_req=1 in cycle N -> rd_valid=1 in cycle N+1, 1-cycle pulse; rd_data = value selected by rd_sel as registered at the end of cycle N, before any cycle-N increment.
REQ-032 Back-to-back rd_req on consecutive cycles: rd_valid high on consecutive cycles, each with its own selection.
REQ-033 rd_sel > NUM_EVT -> rd_data = 0 with rd_valid=1.
REQ-034 rd_data holds its last value while rd_valid=0.
REQ-035 Reads are permitted in every state and do not affect counting.

Reset
REQ-036 rst=1 asynchronously forces state IDLE, all counters 0, ovf=0, rd_valid=0, rd_data=0, done=0, timeout=0.
REQ-037 rst asserted mid-RUN or mid-read discards the pending read; no rd_valid after rst deasserts.

Verification
REQ-038 Basic count: NUM_EVT=4, rst, then en=1, drive evt=4'b0101 for 10 cycles, then halt for 1 cycle -> reads give cnt0=11, cnt1=0, cnt2=11, cycle=11 (evt held during the halt cycle), done=1.
REQ-039 Wrap/saturate: CNT_W=8, evt[0] for 257 cycles -> SAT_MODE=0: cnt0=1, ovf[0]=1; SAT_MODE=1: cnt0=255, ovf[0]=1.
REQ-040 Timeout: CYC_LIMIT=20, en=1, no halt -> timeout=1 and done=1 after 20 RUN cycles, cycle read=20, further evt ignored.
REQ-041 Priority: halt on the cycle the cycle counter reaches CYC_LIMIT -> HALTED, timeout=0; clr together with halt -> IDLE, all counters 0.
REQ-042 Read timing: rd_req with rd_sel=0 while evt[0]=1 and cnt0=5 -> rd_valid next cycle, rd_data=5; rd_sel=7 with NUM_EVT=4 -> rd_data=0.
REQ-043 Async reset: rst pulsed mid-cycle during RUN with cnt0=9 -> outputs 0 immediately without a clock edge, state IDLE.
